spi_word_rx: RTL and testbench

- SPI slave framing stage, directly downstream of the active-low chip-select synchronizer.
- Consumes the synchronized chip select plus already-synchronized SCK/MOSI, all sampled in the system clock domain.
- Detects SCK edges and deserializes MOSI into WORD_W-bit words. Serializes a response word on MISO.
- Hands received words to the actuator register/command logic through a one-cycle valid strobe. Flags truncated frames.

---
 rtl/spi_word_rx_pkg.sv | 18 +
 rtl/spi_word_rx_if.sv | 38 +++
 rtl/spi_word_rx_edge_det.sv | 39 +++
 rtl/spi_word_rx.sv | 167 ++++++++++++++++
 tb/tb_spi_word_rx.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_word_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_word_rx_pkg
// Shared definitions for the SPI word receiver slice.
//   SPI_MODE0 : {CPOL, CPHA} encoding of the only supported SPI mode.
//   state_t   : framing FSM states (ST_IDLE, ST_SHIFT).
// -----------------------------------------------------------------------------
package spi_word_rx_pkg;

  // {CPOL, CPHA}: SCK idles low, data sampled on the rising edge and
  // changed on the falling edge.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : spi_word_rx_pkg

// File: rtl/spi_word_rx_if.sv
// -----------------------------------------------------------------------------
// spi_word_rx_if
// SPI pin bundle as seen in the system clock domain (already synchronized).
//   cs_sn   : chip select, active-low (0 = frame active)
//   sck_s   : SPI clock, mode 0
//   mosi_s  : master-out serial data
//   miso    : slave-out serial data
//   miso_oe : MISO output enable
// Modports:
//   master : drives cs_sn/sck_s/mosi_s, observes miso/miso_oe
//   slave  : observes cs_sn/sck_s/mosi_s, drives miso/miso_oe
// -----------------------------------------------------------------------------
interface spi_word_rx_if;
  import spi_word_rx_pkg::*;

  logic cs_sn;
  logic sck_s;
  logic mosi_s;
  logic miso;
  logic miso_oe;

  modport master (
    output cs_sn,
    output sck_s,
    output mosi_s,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  cs_sn,
    input  sck_s,
    input  mosi_s,
    output miso,
    output miso_oe
  );

endinterface : spi_word_rx_if

// File: rtl/spi_word_rx_edge_det.sv
// -----------------------------------------------------------------------------
// spi_edge_det
// Registers a synchronized serial clock and produces single-cycle pulses on
// its rising and falling transitions. Usable by both slave and master blocks.
//   clock : system clock, posedge
//   reset : synchronous, active-high
//   sig   : synchronized input (e.g. SCK)
//   rise  : sig is 1 now and was 0 last cycle
//   fall  : sig is 0 now and was 1 last cycle
// -----------------------------------------------------------------------------
module spi_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  // Compare the live level against last cycle's level; the pulses are
  // combinational so the consumer acts in the same cycle the edge is seen.
  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule : spi_edge_det

// File: rtl/spi_word_rx.sv
// -----------------------------------------------------------------------------
// spi_word_rx
// SPI mode-0 slave framing stage. Deserializes MOSI into WORD_W-bit words,
// serializes a response word onto MISO, strobes each completed word and flags
// frames that end part-way through a word.
// Parameters:
//   WORD_W    : bits per word (>= 2)
//   MSB_FIRST : 1 = MSB first on both MOSI and MISO, 0 = LSB first
// Ports:
//   clock     : system clock, posedge
//   reset     : synchronous, active-high
//   spi       : SPI pin bundle (slave modport): cs_sn, sck_s, mosi_s in;
//               miso, miso_oe out
//   tx_data   : response word, captured at the start of every word
//   rx_data   : last complete received word, held until the next one
//   rx_valid  : one-cycle pulse when rx_data is updated
//   frame_err : one-cycle pulse when chip select rises with a partial word
//   busy      : high while a frame is in progress (state SHIFT)
// -----------------------------------------------------------------------------
module spi_word_rx
  import spi_word_rx_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  spi_word_rx_if.slave      spi,
  input  logic [WORD_W-1:0] tx_data,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

  // ---------------------------------------------------------------------------
  // SCK edge detection
  // ---------------------------------------------------------------------------
  logic sck_rise;
  logic sck_fall;

  spi_edge_det u_sck_edge (
    .clock (clock),
    .reset (reset),
    .sig   (spi.sck_s),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [WORD_W-1:0] tx_sr_q,     tx_sr_d;
  logic [WORD_W-1:0] rx_sr_q,     rx_sr_d;
  logic [WORD_W-1:0] rx_data_q,   rx_data_d;
  logic              rx_valid_q,  rx_valid_d;
  logic              frame_err_q, frame_err_d;

  // Shifted versions of both shift registers. Selecting on the parameter with
  // a ternary keeps every register bit referenced in either bit order.
  logic [WORD_W-1:0] rx_shifted;
  logic [WORD_W-1:0] tx_shifted;

  assign rx_shifted = MSB_FIRST ? {rx_sr_q[WORD_W-2:0], spi.mosi_s}
                                : {spi.mosi_s, rx_sr_q[WORD_W-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_sr_q[WORD_W-2:0], 1'b0}
                                : {1'b0, tx_sr_q[WORD_W-1:1]};

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // SCK edges here are ignored; only chip select matters.
        if (!spi.cs_sn) begin
          state_d   = ST_SHIFT;
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        if (spi.cs_sn) begin
          // End of frame wins over any SCK edge in the same cycle. A nonzero
          // count means a word was cut short; its bits are dropped.
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          rx_sr_d = rx_shifted;
          if (bit_cnt_q == LAST_BIT) begin
            // Word complete: publish it and immediately arm the next
            // response word so back-to-back words need no gap.
            rx_data_d  = rx_shifted;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            tx_sr_d    = tx_data;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall && (bit_cnt_q != '0)) begin
          // A zero count on a fall means either no bit has been clocked yet
          // or a word just wrapped; the freshly loaded first bit must stay
          // on MISO for the next rising edge.
          tx_sr_d = tx_shifted;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic in_shift;
  logic tx_bit;

  assign in_shift = (state_q == ST_SHIFT);
  assign tx_bit   = MSB_FIRST ? tx_sr_q[WORD_W-1] : tx_sr_q[0];

  // MISO is parked low outside a frame.
  assign spi.miso    = in_shift & tx_bit;
  assign spi.miso_oe = in_shift;
  assign busy        = in_shift;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;

endmodule : spi_word_rx

// File: tb/tb_spi_word_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_word_rx
// Directed bench for spi_word_rx. Two instances share one SPI stimulus:
// dut_m (MSB first) and dut_l (LSB first), each with its own pin bundle.
// -----------------------------------------------------------------------------
module tb_spi_word_rx;

  logic        clock;
  logic        reset;
  logic        cs_sn;
  logic        sck;
  logic        mosi;
  logic [15:0] tx_m;
  logic [15:0] tx_l;

  logic [15:0] rx_data_m, rx_data_l;
  logic        rx_valid_m, rx_valid_l;
  logic        frame_err_m, frame_err_l;
  logic        busy_m, busy_l;

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled away from the active edge.
  int vcnt_m = 0;
  int vcnt_l = 0;
  int ecnt_m = 0;
  int ecnt_l = 0;

  spi_word_rx_if if_m ();
  spi_word_rx_if if_l ();

  assign if_m.cs_sn  = cs_sn;
  assign if_m.sck_s  = sck;
  assign if_m.mosi_s = mosi;
  assign if_l.cs_sn  = cs_sn;
  assign if_l.sck_s  = sck;
  assign if_l.mosi_s = mosi;

  spi_word_rx #(.WORD_W(16), .MSB_FIRST(1'b1)) dut_m (
    .clock     (clock),
    .reset     (reset),
    .spi       (if_m),
    .tx_data   (tx_m),
    .rx_data   (rx_data_m),
    .rx_valid  (rx_valid_m),
    .frame_err (frame_err_m),
    .busy      (busy_m)
  );

  spi_word_rx #(.WORD_W(16), .MSB_FIRST(1'b0)) dut_l (
    .clock     (clock),
    .reset     (reset),
    .spi       (if_l),
    .tx_data   (tx_l),
    .rx_data   (rx_data_l),
    .rx_valid  (rx_valid_l),
    .frame_err (frame_err_l),
    .busy      (busy_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid_m)  vcnt_m <= vcnt_m + 1;
    if (rx_valid_l)  vcnt_l <= vcnt_l + 1;
    if (frame_err_m) ecnt_m <= ecnt_m + 1;
    if (frame_err_l) ecnt_l <= ecnt_l + 1;
  end

  // Advance n clocks; drive and sample 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One SCK pulse: 2 clocks low (MOSI set, MISO sampled before the rise),
  // 2 clocks high. Leaves SCK low; the next call supplies the low phase.
  task automatic send_bit(input logic b, output logic mm, output logic ml);
    mosi = b;
    cyc(2);
    mm  = if_m.miso;
    ml  = if_l.miso;
    sck = 1'b1;
    cyc(2);
    sck = 1'b0;
  endtask

  task automatic start_frame();
    cs_sn = 1'b0;
    cyc(2);
  endtask

  task automatic end_frame();
    cyc(2);
    cs_sn = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cs_sn = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    tx_m  = 16'h0000;
    tx_l  = 16'h0000;
    cyc(3);
    checks++;
    if ({if_m.miso, if_m.miso_oe, rx_valid_m, frame_err_m, busy_m} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {if_m.miso, if_m.miso_oe, rx_valid_m, frame_err_m, busy_m});
    end
    checks++;
    if (rx_data_m !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rx_data: got %h expected 0000", rx_data_m);
    end
    reset = 1'b0;
    cyc(2);
    checks++;
    if ({if_m.miso_oe, busy_m, if_l.miso_oe, busy_l} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {if_m.miso_oe, busy_m, if_l.miso_oe, busy_l});
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_basic_rx();
    logic [15:0] w;
    logic        mm, ml;
    int          v0, e0;
    w  = 16'hA5C3;
    v0 = vcnt_m;
    e0 = ecnt_m;
    start_frame();
    for (int i = 15; i >= 1; i--) send_bit(w[i], mm, ml);
    // Last bit done by hand to pin down the one-clock strobe latency.
    mosi = w[0];
    cyc(2);
    checks++;
    if (rx_valid_m !== 1'b0 || rx_data_m !== 16'h0000) begin
      errors++;
      $display("FAIL basic_pre_edge: got valid=%b data=%h expected valid=0 data=0000",
               rx_valid_m, rx_data_m);
    end
    sck = 1'b1;
    cyc(1);
    checks++;
    if (rx_valid_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid_latency: got %b expected 1", rx_valid_m);
    end
    checks++;
    if (rx_data_m !== 16'hA5C3) begin
      errors++;
      $display("FAIL basic_rx_data: got %h expected a5c3", rx_data_m);
    end
    cyc(1);
    checks++;
    if (rx_valid_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_width: got %b expected 0", rx_valid_m);
    end
    sck = 1'b0;
    end_frame();
    checks++;
    if (vcnt_m - v0 !== 1) begin
      errors++;
      $display("FAIL basic_valid_count: got %0d expected 1", vcnt_m - v0);
    end
    checks++;
    if (ecnt_m - e0 !== 0) begin
      errors++;
      $display("FAIL basic_frame_err: got %0d expected 0", ecnt_m - e0);
    end
    $display("basic_rx: rx_data=%h", rx_data_m);
  endtask

  task automatic test_tx();
    logic [15:0] w, got;
    logic        mm, ml;
    w    = 16'h0F0F;
    tx_m = 16'h1234;
    got  = '0;
    cs_sn = 1'b0;
    checks++;
    if (if_m.miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL tx_oe_before: got %b expected 0", if_m.miso_oe);
    end
    cyc(1);
    checks++;
    if (if_m.miso_oe !== 1'b1 || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL tx_oe_after_cs: got oe=%b busy=%b expected 1 1", if_m.miso_oe, busy_m);
    end
    cyc(1);
    for (int i = 15; i >= 0; i--) begin
      send_bit(w[i], mm, ml);
      got[i] = mm;
    end
    checks++;
    if (got !== 16'h1234) begin
      errors++;
      $display("FAIL tx_miso_word: got %h expected 1234", got);
    end
    cyc(2);
    cs_sn = 1'b1;
    checks++;
    if (if_m.miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL tx_oe_at_cs_rise: got %b expected 1", if_m.miso_oe);
    end
    cyc(1);
    checks++;
    if (if_m.miso_oe !== 1'b0 || if_m.miso !== 1'b0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL tx_oe_after_rise: got oe=%b miso=%b busy=%b expected 0 0 0",
               if_m.miso_oe, if_m.miso, busy_m);
    end
    cyc(1);
    $display("tx: miso word=%h rx_data=%h", got, rx_data_m);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2, got1, got2;
    logic        mm, ml;
    int          v0;
    w1   = 16'hBEEF;
    w2   = 16'h0001;
    tx_m = 16'h1234;
    got1 = '0;
    got2 = '0;
    v0   = vcnt_m;
    start_frame();
    for (int i = 15; i >= 0; i--) begin
      if (i == 8) tx_m = 16'h5555;
      send_bit(w1[i], mm, ml);
      got1[i] = mm;
    end
    checks++;
    if (rx_data_m !== 16'hBEEF) begin
      errors++;
      $display("FAIL b2b_word1: got %h expected beef", rx_data_m);
    end
    for (int i = 15; i >= 0; i--) begin
      send_bit(w2[i], mm, ml);
      got2[i] = mm;
    end
    end_frame();
    checks++;
    if (rx_data_m !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_word2: got %h expected 0001", rx_data_m);
    end
    checks++;
    if (vcnt_m - v0 !== 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d expected 2", vcnt_m - v0);
    end
    checks++;
    if (got1 !== 16'h1234) begin
      errors++;
      $display("FAIL b2b_miso1: got %h expected 1234", got1);
    end
    checks++;
    if (got2 !== 16'h5555) begin
      errors++;
      $display("FAIL b2b_miso2: got %h expected 5555", got2);
    end
    $display("back_to_back: words beef/0001 miso %h/%h", got1, got2);
  endtask

  task automatic test_truncated();
    logic [15:0] w;
    logic        mm, ml;
    int          v0, e0;
    w  = 16'hFFFF;
    v0 = vcnt_m;
    e0 = ecnt_m;
    start_frame();
    for (int i = 15; i >= 9; i--) send_bit(w[i], mm, ml);
    cyc(2);
    cs_sn = 1'b1;
    cyc(1);
    checks++;
    if (frame_err_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL trunc_err_pulse: got err=%b busy=%b expected 1 0", frame_err_m, busy_m);
    end
    cyc(1);
    checks++;
    if (frame_err_m !== 1'b0) begin
      errors++;
      $display("FAIL trunc_err_width: got %b expected 0", frame_err_m);
    end
    checks++;
    if (vcnt_m - v0 !== 0 || rx_data_m !== 16'h0001) begin
      errors++;
      $display("FAIL trunc_no_word: got valid_cnt=%0d data=%h expected 0 0001",
               vcnt_m - v0, rx_data_m);
    end
    checks++;
    if (ecnt_m - e0 !== 1) begin
      errors++;
      $display("FAIL trunc_err_count: got %0d expected 1", ecnt_m - e0);
    end
    w = 16'h3C96;
    start_frame();
    for (int i = 15; i >= 0; i--) send_bit(w[i], mm, ml);
    end_frame();
    checks++;
    if (rx_data_m !== 16'h3C96 || vcnt_m - v0 !== 1) begin
      errors++;
      $display("FAIL trunc_recover: got %h cnt=%0d expected 3c96 cnt=1",
               rx_data_m, vcnt_m - v0);
    end
    $display("truncated: frame_err seen, next word=%h", rx_data_m);
  endtask

  task automatic test_collision();
    logic [15:0] w;
    logic        mm, ml;
    int          v0, e0;
    w  = 16'hFFFF;
    v0 = vcnt_m;
    e0 = ecnt_m;
    start_frame();
    for (int i = 15; i >= 1; i--) send_bit(w[i], mm, ml);
    mosi = 1'b1;
    cyc(2);
    sck   = 1'b1;
    cs_sn = 1'b1;
    cyc(1);
    checks++;
    if (frame_err_m !== 1'b1 || rx_valid_m !== 1'b0) begin
      errors++;
      $display("FAIL collide_pulse: got err=%b valid=%b expected 1 0", frame_err_m, rx_valid_m);
    end
    sck = 1'b0;
    cyc(3);
    checks++;
    if (vcnt_m - v0 !== 0 || ecnt_m - e0 !== 1 || rx_data_m !== 16'h3C96) begin
      errors++;
      $display("FAIL collide_result: got vcnt=%0d ecnt=%0d data=%h expected 0 1 3c96",
               vcnt_m - v0, ecnt_m - e0, rx_data_m);
    end
    $display("collision: last edge dropped, rx_data=%h", rx_data_m);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    logic        mm, ml;
    int          v0, e0;
    w  = 16'hAAAA;
    start_frame();
    for (int i = 15; i >= 11; i--) send_bit(w[i], mm, ml);
    cyc(1);
    reset = 1'b1;
    cs_sn = 1'b1;
    cyc(1);
    checks++;
    if ({if_m.miso, if_m.miso_oe, rx_valid_m, frame_err_m, busy_m} !== 5'b0 ||
        rx_data_m !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_outputs: got ctrl=%b data=%h expected 00000 0000",
               {if_m.miso, if_m.miso_oe, rx_valid_m, frame_err_m, busy_m}, rx_data_m);
    end
    v0 = vcnt_m;
    e0 = ecnt_m;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    checks++;
    if (vcnt_m - v0 !== 0 || ecnt_m - e0 !== 0) begin
      errors++;
      $display("FAIL midreset_no_pulse: got vcnt=%0d ecnt=%0d expected 0 0",
               vcnt_m - v0, ecnt_m - e0);
    end
    w = 16'h00FF;
    start_frame();
    for (int i = 15; i >= 0; i--) send_bit(w[i], mm, ml);
    end_frame();
    checks++;
    if (rx_data_m !== 16'h00FF || vcnt_m - v0 !== 1) begin
      errors++;
      $display("FAIL midreset_recover: got %h cnt=%0d expected 00ff cnt=1",
               rx_data_m, vcnt_m - v0);
    end
    $display("reset_midframe: next word=%h", rx_data_m);
  endtask

  task automatic test_lsb_first();
    logic [15:0] w, got;
    logic        mm, ml;
    int          v0;
    w    = 16'h8001;
    tx_l = 16'h0003;
    got  = '0;
    v0   = vcnt_l;
    start_frame();
    for (int i = 0; i <= 15; i++) begin
      send_bit(w[i], mm, ml);
      got[i] = ml;
    end
    end_frame();
    checks++;
    if (rx_data_l !== 16'h8001) begin
      errors++;
      $display("FAIL lsb_rx_data: got %h expected 8001", rx_data_l);
    end
    checks++;
    if (got !== 16'h0003) begin
      errors++;
      $display("FAIL lsb_miso_word: got %h expected 0003", got);
    end
    checks++;
    if (vcnt_l - v0 !== 1) begin
      errors++;
      $display("FAIL lsb_valid_count: got %0d expected 1", vcnt_l - v0);
    end
    $display("lsb_first: rx_data=%h miso word=%h", rx_data_l, got);
  endtask

  initial begin
    test_reset();
    test_basic_rx();
    test_tx();
    test_back_to_back();
    test_truncated();
    test_collision();
    test_reset_midframe();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_spi_word_rx
